// File: rtl/sound_pkg.sv
// Shared types and constants for the tone sequencer and its note ROM.
// Entry layout: [23] last, [22] rest, [21:15] duration ticks, [14:0] half-period.
package sound_pkg;

    localparam int NOTE_W    = 24;
    localparam int FREQ_W    = 15;
    localparam int DUR_W     = 7;
    localparam int ADDR_W    = 6;
    localparam int ROM_DEPTH = 64;

    localparam int LAST_BIT = 23;
    localparam int REST_BIT = 22;
    localparam int DUR_MSB  = 21;
    localparam int DUR_LSB  = 15;
    localparam int FREQ_MSB = 14;
    localparam int FREQ_LSB = 0;

    typedef enum logic [1:0] {
        TUNE_INTRO = 2'd0,
        TUNE_WAKA  = 2'd1,
        TUNE_DEATH = 2'd2,
        TUNE_FRUIT = 2'd3
    } tune_e;

    typedef struct packed {
        logic              last;
        logic              rest;
        logic [DUR_W-1:0]  dur;
        logic [FREQ_W-1:0] freq;
    } note_t;

    typedef logic [ROM_DEPTH-1:0][NOTE_W-1:0] rom_img_t;

    // Half-period counts at 50 MHz; lower octaves overflow 15 bits.
    localparam logic [FREQ_W-1:0] NOTE_C6 = 15'd23889;
    localparam logic [FREQ_W-1:0] NOTE_D6 = 15'd21282;
    localparam logic [FREQ_W-1:0] NOTE_E6 = 15'd18961;
    localparam logic [FREQ_W-1:0] NOTE_F6 = 15'd17897;
    localparam logic [FREQ_W-1:0] NOTE_G6 = 15'd15944;
    localparam logic [FREQ_W-1:0] NOTE_A6 = 15'd14205;
    localparam logic [FREQ_W-1:0] NOTE_B6 = 15'd12655;
    localparam logic [FREQ_W-1:0] NOTE_C7 = 15'd11945;

    function automatic note_t mk_note(
        input logic              last,
        input logic              rest,
        input logic [DUR_W-1:0]  dur,
        input logic [FREQ_W-1:0] freq
    );
        note_t n;
        n.last = last;
        n.rest = rest;
        n.dur  = dur;
        n.freq = freq;
        return n;
    endfunction

    function automatic rom_img_t default_tunes();
        rom_img_t r;
        r = '0;
        r[6'h00] = mk_note(1'b0, 1'b0, 7'd20, NOTE_C6);
        r[6'h01] = mk_note(1'b0, 1'b0, 7'd20, NOTE_E6);
        r[6'h02] = mk_note(1'b0, 1'b0, 7'd20, NOTE_G6);
        r[6'h03] = mk_note(1'b1, 1'b0, 7'd40, NOTE_C7);
        r[6'h10] = mk_note(1'b0, 1'b0, 7'd8, NOTE_G6);
        r[6'h11] = mk_note(1'b1, 1'b0, 7'd8, NOTE_E6);
        r[6'h20] = mk_note(1'b0, 1'b0, 7'd10, NOTE_C7);
        r[6'h21] = mk_note(1'b0, 1'b0, 7'd10, NOTE_B6);
        r[6'h22] = mk_note(1'b0, 1'b0, 7'd10, NOTE_A6);
        r[6'h23] = mk_note(1'b0, 1'b0, 7'd10, NOTE_G6);
        r[6'h24] = mk_note(1'b0, 1'b0, 7'd10, NOTE_F6);
        r[6'h25] = mk_note(1'b0, 1'b0, 7'd10, NOTE_E6);
        r[6'h26] = mk_note(1'b0, 1'b0, 7'd10, NOTE_D6);
        r[6'h27] = mk_note(1'b1, 1'b0, 7'd30, NOTE_C6);
        r[6'h30] = mk_note(1'b0, 1'b0, 7'd5, NOTE_C7);
        r[6'h31] = mk_note(1'b0, 1'b0, 7'd5, NOTE_E6);
        r[6'h32] = mk_note(1'b0, 1'b0, 7'd5, NOTE_C7);
        r[6'h33] = mk_note(1'b1, 1'b0, 7'd10, NOTE_G6);
        return r;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the game FSM and the tone sequencer,
// including the tone outputs consumed by the speaker driver.
interface tone_sequencer_if;
    import sound_pkg::*;

    logic              start;
    logic [1:0]        tune_sel;
    logic              stop;
    logic              busy;
    logic              done;
    logic              play;
    logic [FREQ_W-1:0] frequency;

    modport master (
        output start, tune_sel, stop,
        input  busy, done, play, frequency
    );

    modport slave (
        input  start, tune_sel, stop,
        output busy, done, play, frequency
    );

endinterface

// File: rtl/tone_rom.sv
// 64 x 24 note ROM with a registered read port (one cycle of latency).
// Contents come from the ROM_INIT image so each build can carry its own tunes.
module tone_rom
    import sound_pkg::*;
#(
    parameter rom_img_t ROM_INIT = default_tunes()
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output note_t             data_o
);

    note_t data_q;

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            data_q <= ROM_INIT[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/tone_sequencer.sv
// Plays one of four stored tunes note by note, each note followed by a
// silent gap, driving the speaker's play/half-period inputs.
module tone_sequencer
    import sound_pkg::*;
#(
    parameter int       TICK_DIV  = 500000,
    parameter int       GAP_TICKS = 1,
    parameter rom_img_t ROM_INIT  = default_tunes()
) (
    input  logic           clk,
    input  logic           rst,
    tone_sequencer_if.slave bus
);

    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_NOTE  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              ld_q, ld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              play_q, play_d;
    logic [FREQ_W-1:0] freq_q, freq_d;

    note_t note;
    logic  tick_hit;
    logic  tune_end;

    tone_rom #(
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk     (clk),
        .rd_en_i (state_q == S_FETCH),
        .addr_i  (addr_q),
        .data_o  (note)
    );

    assign tick_hit = (tick_q == TICK_W'(TICK_DIV - 1));
    assign tune_end = note.last | (addr_q[3:0] == 4'hF);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tick_d  = tick_hit ? '0 : tick_q + 1'b1;
        dur_d   = dur_q;
        ld_d    = ld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        play_d  = play_q;
        freq_d  = freq_q;

        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = S_FETCH;
                    addr_d  = {bus.tune_sel, 4'h0};
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_NOTE;
                ld_d    = 1'b1;
                tick_d  = '0;
            end
            S_NOTE: begin
                // First NOTE cycle: ROM data has just arrived.
                if (ld_q) begin
                    ld_d   = 1'b0;
                    tick_d = '0;
                    freq_d = note.freq;
                    play_d = ~note.rest & (note.freq != '0);
                    dur_d  = (note.dur == '0) ? DUR_W'(1) : note.dur;
                end else if (tick_hit) begin
                    dur_d = dur_q - 1'b1;
                    if (dur_q == DUR_W'(1)) begin
                        state_d = S_GAP;
                        play_d  = 1'b0;
                        dur_d   = DUR_W'(GAP_TICKS);
                    end
                end
            end
            S_GAP: begin
                if (GAP_TICKS == 0 || (tick_hit && dur_q == DUR_W'(1))) begin
                    if (tune_end) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        freq_d  = '0;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + 1'b1;
                    end
                end else if (tick_hit) begin
                    dur_d = dur_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && bus.stop) begin
            state_d = S_IDLE;
            ld_d    = 1'b0;
            tick_d  = '0;
            dur_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            play_d  = 1'b0;
            freq_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            play_q  <= 1'b0;
            freq_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            play_q  <= play_d;
            freq_q  <= freq_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.play      = play_q;
    assign bus.frequency = freq_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: expected waveforms are derived from the note
// table with plain cycle arithmetic and compared every clock.
module tb_tone_sequencer;
    import sound_pkg::*;

    localparam int TD = 4;
    localparam int GT = 1;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        play;
        logic [14:0] freq;
    } obs_t;

    function automatic note_t ent(input int a);
        if (a >= 32 && a < 48) begin
            return mk_note(1'b0, 1'b0, 7'(1 + a % 2), 15'(a + 256));
        end
        case (a)
            0:  return mk_note(1'b0, 1'b0, 7'd3, NOTE_C6);
            1:  return mk_note(1'b0, 1'b1, 7'd3, 15'h1000);
            2:  return mk_note(1'b0, 1'b0, 7'd2, NOTE_E6);
            3:  return mk_note(1'b1, 1'b0, 7'd1, NOTE_G6);
            16: return mk_note(1'b0, 1'b0, 7'd2, 15'h61A8);
            17: return mk_note(1'b1, 1'b0, 7'd1, 15'h30D4);
            48: return mk_note(1'b0, 1'b0, 7'd0, 15'h2222);
            49: return mk_note(1'b0, 1'b0, 7'd0, 15'h0000);
            50: return mk_note(1'b1, 1'b0, 7'd1, 15'h3333);
            default: return '0;
        endcase
    endfunction

    function automatic rom_img_t img();
        rom_img_t r;
        for (int i = 0; i < ROM_DEPTH; i++) r[i] = ent(i);
        return r;
    endfunction

    localparam rom_img_t IMG = img();

    logic clk = 1'b0;
    logic rst;
    tone_sequencer_if bus ();

    tone_sequencer #(
        .TICK_DIV  (TD),
        .GAP_TICKS (GT),
        .ROM_INIT  (IMG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    int   ph_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input obs_t e);
        obs_t o;
        o = '{bus.busy, bus.done, bus.play, bus.frequency};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s t=%0t: observed busy=%0b done=%0b play=%0b freq=%h, expected busy=%0b done=%0b play=%0b freq=%h",
                   tag, $time, o.busy, o.done, o.play, o.freq,
                   e.busy, e.done, e.play, e.freq);
        end
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            step();
            check(tag, '0);
        end
    endtask

    // One entry per clock after the start cycle; phase 0 fetch, 1 note, 2 gap, 3 done.
    task automatic build(input int t);
        logic [14:0] pf;
        note_t       n;
        int          a, d, g;
        logic        p;
        exp_q.delete();
        ph_q.delete();
        pf = '0;
        a  = t * 16;
        g  = (GT == 0) ? 1 : GT * TD;
        forever begin
            n = ent(a);
            d = (n.dur == 0) ? 1 : int'(n.dur);
            p = !n.rest && (n.freq != 0);
            repeat (2) begin
                exp_q.push_back('{1'b1, 1'b0, 1'b0, pf});
                ph_q.push_back(0);
            end
            repeat (d * TD) begin
                exp_q.push_back('{1'b1, 1'b0, p, n.freq});
                ph_q.push_back(1);
            end
            repeat (g) begin
                exp_q.push_back('{1'b1, 1'b0, 1'b0, n.freq});
                ph_q.push_back(2);
            end
            pf = n.freq;
            if (n.last || a % 16 == 15) begin
                exp_q.push_back('{1'b0, 1'b1, 1'b0, 15'h0});
                ph_q.push_back(3);
                break;
            end
            a++;
        end
    endtask

    task automatic run(input int t, input int stop_at, input int rst_after,
                       input bit junk, input string tag);
        bus.tune_sel = 2'(t);
        bus.start    = 1'b1;
        build(t);
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            bus.start    = 1'b0;
            bus.tune_sel = 2'($urandom);
            check(tag, exp_q[i]);
            if (i == stop_at) begin
                bus.stop = 1'b1;
                step();
                bus.stop = 1'b0;
                check({tag, "_stop"}, '0);
                return;
            end
            if (rst_after >= 0 && i >= rst_after && ph_q[i] == 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check({tag, "_rst"}, '0);
                return;
            end
            if (junk && exp_q[i].busy && $urandom_range(0, 3) == 0) begin
                bus.start = 1'b1;
            end
        end
    endtask

    initial begin
        int t, s;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.tune_sel = 2'd0;
        rst          = 1'b1;
        step();
        step();
        check("reset", '0);
        rst = 1'b0;
        idle(1, "reset_idle");

        run(1, -1, -1, 1'b0, "t1_tune1");
        idle(2, "t1_idle");

        run(0, -1, -1, 1'b0, "t2_rest");
        idle(1, "t2_idle");

        run(2, -1, -1, 1'b0, "t3_16note");
        idle(2, "t3_idle");

        run(0, $urandom_range(3, 12), -1, 1'b0, "t4_stop");
        run(1, -1, -1, 1'b0, "t4_restart");
        idle(1, "t4_idle");

        bus.tune_sel = 2'd1;
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("t5_startstop", '0);
        idle(2, "t5_idle");
        run(2, -1, -1, 1'b1, "t5_junk");
        idle(1, "t5_idle2");

        run(3, -1, -1, 1'b0, "t6_dur0");
        idle(1, "t6_idle");
        run(1, -1, $urandom_range(0, 10), 1'b0, "t6_rst");
        idle(2, "t6_after_rst");

        repeat (6) begin
            t = $urandom_range(0, 3);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            idle($urandom_range(0, 3), "rand_idle");
            run(t, s, -1, 1'b1, "rand");
        end
        idle(2, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
